gcd_result_queue: RTL

//  Downstream stage of the GCD core. GCD output has valid only (no ready), so results land here.

---
 rtl/gcd_result_queue_if.sv | 33 +++
 rtl/gcd_result_queue.sv | 93 +++++++++
 2 files changed

// File: rtl/gcd_result_queue_if.sv
// Port bundle of the GCD result queue: issue credits, GCD result input, dequeue port and status.
// The slave modport is the queue's view; the master modport is the surrounding environment's view.
interface gcd_result_queue_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             issue_fire;
   logic             issue_allow;
   logic             res_valid;
   logic [WIDTH-1:0] res_bits;
   logic             deq_valid;
   logic             deq_ready;
   logic [WIDTH-1:0] deq_bits;
   logic [CW-1:0]    count;
   logic [CW-1:0]    inflight;
   logic             err_overflow;
   logic             err_orphan;
   logic             err_credit;

   modport slave (
      input  issue_fire, res_valid, res_bits, deq_ready,
      output issue_allow, deq_valid, deq_bits, count, inflight,
             err_overflow, err_orphan, err_credit
   );

   modport master (
      output issue_fire, res_valid, res_bits, deq_ready,
      input  issue_allow, deq_valid, deq_bits, count, inflight,
             err_overflow, err_orphan, err_credit
   );
endinterface

// File: rtl/gcd_result_queue.sv
// Buffers GCD results (valid-only source) in a DEPTH-entry FIFO behind a valid/ready port and
// issues upstream credits so that every outstanding job is guaranteed a FIFO slot.
module gcd_result_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input logic              clk_i,
   input logic              rst_i,
   gcd_result_queue_if.slave q_if
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic             err_overflow_q, err_overflow_d;
   logic             err_orphan_q, err_orphan_d;
   logic             err_credit_q, err_credit_d;

   logic             deq_valid, full, deq_fire, enq, res_ret, issue_allow;
   logic [CW:0]      credit_sum, inflight_sum;

   // Every output below is a function of registers only.
   assign deq_valid   = (count_q != '0);
   assign full        = (count_q == CW'(DEPTH));
   assign credit_sum  = {1'b0, count_q} + {1'b0, inflight_q};
   assign issue_allow = (credit_sum < DEPTH_W);

   always_comb begin
      deq_fire = deq_valid & q_if.deq_ready;
      enq      = q_if.res_valid & (!full | deq_fire);
      res_ret  = q_if.res_valid & (inflight_q != '0);

      rd_ptr_d = rd_ptr_q;
      if (deq_fire) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      wr_ptr_d = wr_ptr_q;
      if (enq) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);

      count_d = count_q + CW'(enq) - CW'(deq_fire);

      // A credit violation can push inflight past DEPTH; it is held at DEPTH instead.
      inflight_sum = {1'b0, inflight_q} + (CW + 1)'(q_if.issue_fire) - (CW + 1)'(res_ret);
      inflight_d   = (inflight_sum > DEPTH_W) ? CW'(DEPTH) : inflight_sum[CW-1:0];

      err_overflow_d = err_overflow_q | (q_if.res_valid & full & !deq_fire);
      err_orphan_d   = err_orphan_q | (q_if.res_valid & (inflight_q == '0));
      err_credit_d   = err_credit_q | (q_if.issue_fire & !issue_allow);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the same pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         inflight_q     <= '0;
         err_overflow_q <= 1'b0;
         err_orphan_q   <= 1'b0;
         err_credit_q   <= 1'b0;
      end else begin
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         inflight_q     <= inflight_d;
         err_overflow_q <= err_overflow_d;
         err_orphan_q   <= err_orphan_d;
         err_credit_q   <= err_credit_d;
      end
   end

   // NOTE: the data array has no reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (enq && !rst_i) mem_q[wr_ptr_q] <= q_if.res_bits;
   end

   assign q_if.issue_allow  = issue_allow;
   assign q_if.deq_valid    = deq_valid;
   assign q_if.deq_bits     = deq_valid ? mem_q[rd_ptr_q] : '0;
   assign q_if.count        = count_q;
   assign q_if.inflight     = inflight_q;
   assign q_if.err_overflow = err_overflow_q;
   assign q_if.err_orphan   = err_orphan_q;
   assign q_if.err_credit   = err_credit_q;

   // With well-behaved neighbours every job owns exactly one slot, queued or still in flight.
   a_credit_bound : assert property (@(posedge clk_i) disable iff (rst_i)
      (err_overflow_q || err_orphan_q || err_credit_q || credit_sum <= DEPTH_W));
endmodule
